// File: rtl/div_unit_pkg.sv
// div_unit_pkg: constants and types shared by the divider and its neighbours.
//   DIV_XLEN      : datapath width
//   OPC_* / F7_* / F3_* : decoder constants for the M-extension divide group
//   div_op_t      : low two bits of funct3 for the four divide ops
//   div_state_t   : divider FSM states
package div_unit_pkg;

  localparam int DIV_XLEN = 64;

  localparam logic [6:0] OPC_INSTR_R  = 7'b0110011;
  localparam logic [6:0] OPC_INSTR_RW = 7'b0111011;
  localparam logic [6:0] F7_MULDIV    = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between decode, divider and memory stage.
//   in_valid/in_ready   : request handshake (funct3, is_word, a, b)
//   flush               : kill whatever the divider is doing
//   out_valid/out_ready : result handshake (result)
// master = pipeline side, slave = divider.
interface div_unit_if #(parameter int XLEN = 64) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            is_word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, is_word, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, is_word, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one restoring-division iteration, purely combinational.
//   i_rem  : partial remainder (always < i_div on entry)
//   i_msb  : next dividend bit shifted in
//   i_div  : |divisor|
//   o_rem  : next partial remainder
//   o_qbit : quotient bit (1 when the trial subtraction did not borrow)
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_msb,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);
  // One extra bit: the shifted remainder can reach 2*|b|-1, which needs XLEN+1 bits
  // for full-range unsigned divisors. The top bit of the difference is the borrow.
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {1'b0, i_div};
  assign o_qbit  = ~w_diff[XLEN];
  assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU(+W).
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : div_unit_if.slave (request, flush, result handshakes)
// One quotient bit per cycle on magnitudes; signs are fixed on the way into DONE.
// Build option: DIV_EARLY_OUT_EN sends divide-by-zero and signed overflow
// straight from IDLE to DONE; otherwise they take the full iteration count.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | iterating, r_cnt counts finished iterations
// DONE  | result held, out_valid high until out_ready
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  div_unit_if.slave   bus
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       r_state;
  logic [XLEN-1:0]  r_q;       // dividend bits shift out the top, quotient bits in the bottom
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_div;
  logic [XLEN-1:0]  r_result;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic             r_word;
  logic             r_is_rem;
  logic             r_legal;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;

  // request-side decode
  div_op_t          w_op;
  logic             w_signed;
  logic             w_accept;
  logic [XLEN-1:0]  w_a_ext;
  logic [XLEN-1:0]  w_b_ext;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_a_abs;
  logic [XLEN-1:0]  w_b_abs;
  logic             w_div0;

  assign w_op     = div_op_t'(bus.funct3[1:0]);
  assign w_signed = (w_op == DIV) || (w_op == REM);
  assign w_accept = bus.in_valid && bus.in_ready && !bus.flush;

  assign w_a_ext = !bus.is_word ? bus.a :
                   {{(XLEN-32){w_signed & bus.a[31]}}, bus.a[31:0]};
  assign w_b_ext = !bus.is_word ? bus.b :
                   {{(XLEN-32){w_signed & bus.b[31]}}, bus.b[31:0]};
  assign w_a_neg = w_signed && w_a_ext[XLEN-1];
  assign w_b_neg = w_signed && w_b_ext[XLEN-1];
  assign w_a_abs = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_abs = w_b_neg ? -w_b_ext : w_b_ext;
  assign w_div0  = (w_b_ext == '0);

`ifdef DIV_EARLY_OUT_EN
  logic [XLEN-1:0] w_min;
  logic [XLEN-1:0] w_a_res;
  logic            w_ovf;
  logic            w_early;
  logic [XLEN-1:0] w_early_res;

  assign w_min       = bus.is_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_ovf       = w_signed && (w_b_ext == '1) && (w_a_ext == w_min);
  assign w_early     = bus.funct3[2] && (w_div0 || w_ovf);
  assign w_a_res     = bus.is_word ? {{(XLEN-32){bus.a[31]}}, bus.a[31:0]} : bus.a;
  assign w_early_res = bus.funct3[1] ? (w_div0 ? w_a_res : '0)
                                     : (w_div0 ? '1 : w_a_res);
`endif

  // iteration and sign fix
  logic [XLEN-1:0] w_rem_nxt;
  logic            w_qbit;
  logic [XLEN-1:0] w_q_nxt;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_sel;
  logic [XLEN-1:0] w_final;

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_q[XLEN-1]),
    .i_div  (r_div),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_q_nxt = {r_q[XLEN-2:0], w_qbit};
  assign w_q_fix = r_neg_q ? -w_q_nxt : w_q_nxt;
  assign w_r_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  // The natural remainder already equals the dividend for b=0 and both overflow
  // results fall out of the magnitude path; only the div-by-zero quotient needs
  // overriding, since a negative dividend would otherwise flip its sign.
  assign w_sel   = r_is_rem ? w_r_fix : (r_div0 ? '1 : w_q_fix);
  assign w_final = !r_legal ? '0 :
                   (r_word ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_n      <= '0;
      r_word   <= 1'b0;
      r_is_rem <= 1'b0;
      r_legal  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_word   <= bus.is_word;
            r_is_rem <= bus.funct3[1];
            r_legal  <= bus.funct3[2];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= w_div0;
            r_div    <= w_b_abs;
            r_rem    <= '0;
            r_cnt    <= '0;
            // W ops start with the 32-bit magnitude at the top so the MSB walk begins at bit 31
            r_q      <= bus.is_word ? {w_a_abs[31:0], {(XLEN-32){1'b0}}} : w_a_abs;
            r_n      <= bus.is_word ? CNT_W'(32) : CNT_W'(XLEN);
            r_state  <= S_CALC;
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_result <= w_early_res;
              r_state  <= S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == r_n - CNT_W'(1)) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !reset;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
endmodule
